cache_ctrl_fsm: RTL

- Sequencing controller for the 8-set, 4-way cache with 5-bit tags. It accepts CPU read/write requests, performs the tag lookup, and selects the victim with true-LRU age counters.
- On a read miss it fetches the word from memory and refills the victim way. Writes are write-through, no-write-allocate.
- Sits between the CPU request port and the main-memory port. It owns the tag/valid array, the data array and the per-set LRU state.

---
 rtl/cache_ctrl_fsm_if.sv | 30 +++
 rtl/cache_ctrl_fsm.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm_if.sv
// cache_ctrl_fsm_if: CPU request/response and main-memory handshake bundle for the cache controller.
interface cache_ctrl_fsm_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: 4-way set-associative, write-through/no-write-allocate cache controller with true-LRU ages.
module cache_ctrl_fsm #(
    parameter int SETS   = 8,
    parameter int WAYS   = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    cache_ctrl_fsm_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int AW    = TAG_W + IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, REFILL, RESP} state_t;

    state_t                                     state_q, state_d;
    logic                                       we_q, we_d, hit_q, hit_d;
    logic [AW-1:0]                              addr_q, addr_d;
    logic [DATA_W-1:0]                          wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]                                 victim_q, victim_d;
    logic [SETS-1:0][WAYS-1:0]                  valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][DATA_W-1:0]      data_q, data_d;
    logic [SETS-1:0][WAYS-1:0][1:0]             age_q, age_d;

    logic [IDX_W-1:0] set;
    logic [TAG_W-1:0] tag;
    logic [WAYS-1:0]  hit_vec;
    logic [1:0]       hit_way, victim;

    // Ways younger than the accessed one age by one; the accessed way becomes newest.
    function automatic logic [WAYS-1:0][1:0] lru_upd(input logic [WAYS-1:0][1:0] a, input logic [1:0] w);
        lru_upd = a;
        for (int i = 0; i < WAYS; i++) if (a[i] < a[w]) lru_upd[i] = a[i] + 2'd1;
        lru_upd[w] = 2'd0;
    endfunction

    always_comb begin
        set     = addr_q[IDX_W-1:0];
        tag     = addr_q[AW-1:IDX_W];
        hit_vec = '0;
        hit_way = '0;
        victim  = '0;
        for (int i = 0; i < WAYS; i++) hit_vec[i] = valid_q[set][i] && tag_q[set][i] == tag;
        for (int i = 0; i < WAYS; i++) if (hit_vec[i]) hit_way = 2'(i);
        for (int i = 0; i < WAYS; i++) if (age_q[set][i] == 2'd3) victim = 2'(i);
        for (int i = WAYS - 1; i >= 0; i--) if (!valid_q[set][i]) victim = 2'(i);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        hit_d    = hit_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        victim_d = victim_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        age_d    = age_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                hit_d   = |hit_vec;
                rdata_d = '0;
                if (|hit_vec) begin
                    age_d[set] = lru_upd(age_q[set], hit_way);
                    if (we_q) data_d[set][hit_way] = wdata_q;
                    else rdata_d = data_q[set][hit_way];
                end
                victim_d = victim;
                state_d  = we_q ? MEM_WR : (|hit_vec ? RESP : MEM_RD);
            end
            MEM_RD: if (bus.mem_ack) begin
                rdata_d = bus.mem_rdata;
                state_d = REFILL;
            end
            REFILL: begin
                data_d[set][victim_q]  = rdata_q;
                tag_d[set][victim_q]   = tag;
                valid_d[set][victim_q] = 1'b1;
                age_d[set]             = lru_upd(age_q[set], victim_q);
                state_d                = RESP;
            end
            MEM_WR: state_d = bus.mem_ack ? RESP : MEM_WR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            hit_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            victim_q <= '0;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= 2'(w);
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            hit_q    <= hit_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            age_q    <= age_d;
        end
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.mem_req    = state_q == MEM_RD || state_q == MEM_WR;
    assign bus.mem_we     = state_q == MEM_WR;
    assign bus.mem_addr   = bus.mem_req ? addr_q : '0;
    assign bus.mem_wdata  = state_q == MEM_WR ? wdata_q : '0;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = state_q == RESP ? rdata_q : '0;
    assign bus.resp_hit   = state_q == RESP && hit_q;
endmodule
